// File: rtl/byte_en_bypass_bram_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : byte_en_bypass_bram_if
//  Purpose  : Port bundle for byte_en_bypass_bram. Port A is write-only with
//             per-byte mask, port B is a read port with a valid strobe, and
//             busy flags the post-reset clear sweep.
//  Revision : 1.0  initial release
// ============================================================================
interface byte_en_bypass_bram_if #(
    parameter int WID  = 32,
    parameter int SIZE = 256
);
    localparam int c_NB = WID / 8;
    localparam int c_AW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic              ena;
    logic [c_NB-1:0]   wea;
    logic [c_AW-1:0]   addra;
    logic [WID-1:0]    dina;
    logic              enb;
    logic [c_AW-1:0]   addrb;
    logic [WID-1:0]    doutb;
    logic              rvalidb;
    logic              busy;

    // Requester side: drives both ports, observes read data and busy
    modport master (
        output ena, wea, addra, dina, enb, addrb,
        input  doutb, rvalidb, busy
    );

    // Memory side
    modport slave (
        input  ena, wea, addra, dina, enb, addrb,
        output doutb, rvalidb, busy
    );
endinterface
`default_nettype wire

// File: rtl/byte_en_bypass_bram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : byte_en_bypass_bram
//  Purpose  : Simple dual-port block RAM. Byte-masked writes on port A,
//             registered reads on port B with read-during-write bypass,
//             optional zero-fill sweep after reset, 1- or 2-cycle read
//             latency with a valid strobe.
//  Revision : 1.0  initial release
// ============================================================================
module byte_en_bypass_bram #(
    parameter int WID        = 32,
    parameter int SIZE       = 256,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    byte_en_bypass_bram_if.slave  bus
);

    localparam int c_NB = WID / 8;
    localparam int c_AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    // One extra bit so the terminal compare never wraps for power-of-two SIZE
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(SIZE - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    logic [c_CW-1:0]   cnt_q;
    logic              busy_q;

    // Clear sequencer: one zero word per cycle from address 0 to SIZE-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= (INIT_CLEAR != 0);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                ST_CLEAR: begin
                    if (cnt_q == c_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;

    // ------------------------------------------------------------------------
    // Port qualification and write-port steering
    // ------------------------------------------------------------------------
    logic              w_rd_acc;
    logic [c_NB-1:0]   w_mem_we;
    logic [c_AW-1:0]   w_mem_addr;
    logic [WID-1:0]    w_mem_din;

    // The sweep owns the write port while busy; user traffic is dropped
    always_comb begin
        w_rd_acc   = bus.enb & ~busy_q;
        w_mem_we   = '0;
        w_mem_addr = bus.addra;
        w_mem_din  = bus.dina;
        if (busy_q) begin
            w_mem_we   = '1;
            w_mem_addr = cnt_q[c_AW-1:0];
            w_mem_din  = '0;
        end else if (bus.ena) begin
            w_mem_we   = bus.wea;
        end
    end

    // ------------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------------
    logic [WID-1:0]    mem [SIZE];
    logic [WID-1:0]    ram_q;

    // Byte-masked write and registered read; the read returns the word as it
    // stood before this edge's write, the bypass below patches in new bytes
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NB; i++) begin
            if (w_mem_we[i]) begin
                mem[w_mem_addr][8*i +: 8] <= w_mem_din[8*i +: 8];
            end
        end
        if (w_rd_acc) begin
            ram_q <= mem[bus.addrb];
        end
    end

    // ------------------------------------------------------------------------
    // Read-during-write bypass capture
    // ------------------------------------------------------------------------
    logic [c_NB-1:0]   byp_mask_d, byp_mask_q;
    logic [WID-1:0]    byp_data_d, byp_data_q;
    logic              rv1_d, rv1_q;

    // Capture which bytes of the read word are being overwritten this cycle
    always_comb begin
        byp_mask_d = byp_mask_q;
        byp_data_d = byp_data_q;
        rv1_d      = w_rd_acc;
        if (w_rd_acc) begin
            byp_mask_d = (bus.ena && (bus.addra == bus.addrb)) ? bus.wea : '0;
            byp_data_d = bus.dina;
        end
    end

    // A reset mask of all ones with zero data forces the merged word to zero
    // without putting a reset on the RAM's own read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_mask_q <= '1;
            byp_data_q <= '0;
            rv1_q      <= 1'b0;
        end else begin
            byp_mask_q <= byp_mask_d;
            byp_data_q <= byp_data_d;
            rv1_q      <= rv1_d;
        end
    end

    logic [WID-1:0]    w_merged;

    // Per-byte merge of bypassed write data over the stored word
    always_comb begin
        w_merged = ram_q;
        for (int i = 0; i < c_NB; i++) begin
            if (byp_mask_q[i]) begin
                w_merged[8*i +: 8] = byp_data_q[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WID-1:0] dout_d, dout_q;
            logic           rv2_d, rv2_q;

            // Extra register stage; only loads when a read result arrives
            always_comb begin
                dout_d = rv1_q ? w_merged : dout_q;
                rv2_d  = rv1_q;
            end

            // Output register with reset to zero
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                    rv2_q  <= 1'b0;
                end else begin
                    dout_q <= dout_d;
                    rv2_q  <= rv2_d;
                end
            end

            assign bus.doutb   = dout_q;
            assign bus.rvalidb = rv2_q;
        end else begin : g_no_out_reg
            // Merge sources only change on a read, so the output holds between reads
            assign bus.doutb   = w_merged;
            assign bus.rvalidb = rv1_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_byte_en_bypass_bram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_byte_en_bypass_bram
//  Purpose  : Self-checking bench for byte_en_bypass_bram. Two instances
//             (OUT_REG=0 and OUT_REG=1) share one stimulus stream; a
//             reference memory produces expected read words which are queued
//             per instance and compared when rvalidb fires.
//  Revision : 1.0  initial release
// ============================================================================
module tb_byte_en_bypass_bram;

    localparam int c_WID  = 32;
    localparam int c_SIZE = 256;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        enb = 1'b0;
    logic [3:0]  wea = '0;
    logic [7:0]  addra = '0;
    logic [7:0]  addrb = '0;
    logic [31:0] dina = '0;

    int          cyc = 0;
    int          sweep_left = c_SIZE;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] model [c_SIZE];
    logic [31:0] last_out [2];
    exp_t        q0 [$];
    exp_t        q1 [$];

    always #5 clk = ~clk;

    byte_en_bypass_bram_if #(.WID(c_WID), .SIZE(c_SIZE)) bus0 ();
    byte_en_bypass_bram_if #(.WID(c_WID), .SIZE(c_SIZE)) bus1 ();

    assign bus0.ena = ena;   assign bus1.ena = ena;
    assign bus0.wea = wea;   assign bus1.wea = wea;
    assign bus0.addra = addra; assign bus1.addra = addra;
    assign bus0.dina = dina; assign bus1.dina = dina;
    assign bus0.enb = enb;   assign bus1.enb = enb;
    assign bus0.addrb = addrb; assign bus1.addrb = addrb;

    byte_en_bypass_bram #(.WID(c_WID), .SIZE(c_SIZE), .OUT_REG(0), .INIT_CLEAR(1)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    byte_en_bypass_bram #(.WID(c_WID), .SIZE(c_SIZE), .OUT_REG(1), .INIT_CLEAR(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Edge counter and bench-side view of the sweep (edges still to be swept)
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) sweep_left = c_SIZE;
        else if (sweep_left > 0) sweep_left--;
    end

    task automatic mon(input int idx, input logic rv, input logic [31:0] dout, input logic bsy);
        exp_t e;
        int   have;
        if (!rst_n) begin
            chk_eq($sformatf("d%0d_rst_rvalid", idx), {31'b0, rv}, 32'd0);
            chk_eq($sformatf("d%0d_rst_dout", idx), dout, 32'd0);
            chk_eq($sformatf("d%0d_rst_busy", idx), {31'b0, bsy}, 32'd1);
            last_out[idx] = '0;
        end else begin
            chk_eq($sformatf("d%0d_busy", idx), {31'b0, bsy}, {31'b0, (sweep_left > 0)});
            have = (idx == 0) ? q0.size() : q1.size();
            if (rv) begin
                if (have == 0) begin
                    chk_eq($sformatf("d%0d_spurious_rvalid", idx), {31'b0, rv}, 32'd0);
                end else begin
                    e = (idx == 0) ? q0.pop_front() : q1.pop_front();
                    chk_eq($sformatf("d%0d_latency", idx), cyc, e.due);
                    chk_eq($sformatf("d%0d_rdata", idx), dout, e.data);
                    last_out[idx] = e.data;
                end
            end else begin
                chk_eq($sformatf("d%0d_hold", idx), dout, last_out[idx]);
                if (have > 0) begin
                    e = (idx == 0) ? q0[0] : q1[0];
                    if (e.due <= cyc) begin
                        if (idx == 0) void'(q0.pop_front());
                        else          void'(q1.pop_front());
                        chk_eq($sformatf("d%0d_missing_rvalid", idx), {31'b0, rv}, 32'd1);
                    end
                end
            end
        end
    endtask

    // Outputs are sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        mon(0, bus0.rvalidb, bus0.doutb, bus0.busy);
        mon(1, bus1.rvalidb, bus1.doutb, bus1.busy);
    end

    // One clock of stimulus; model updated as the DUT should at the next edge
    task automatic step(input logic i_ena, input logic [3:0] i_wea, input logic [7:0] i_addra,
                        input logic [31:0] i_dina, input logic i_enb, input logic [7:0] i_addrb);
        logic [31:0] rd;
        ena = i_ena; wea = i_wea; addra = i_addra; dina = i_dina;
        enb = i_enb; addrb = i_addrb;
        if (sweep_left == 0) begin
            if (i_enb) begin
                rd = model[i_addrb];
                if (i_ena && (i_addra == i_addrb)) begin
                    for (int b = 0; b < 4; b++)
                        if (i_wea[b]) rd[8*b +: 8] = i_dina[8*b +: 8];
                end
                q0.push_back('{rd, cyc + 1});
                q1.push_back('{rd, cyc + 2});
            end
            if (i_ena) begin
                for (int b = 0; b < 4; b++)
                    if (i_wea[b]) model[i_addra][8*b +: 8] = i_dina[8*b +: 8];
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 4'h0, 8'd0, 32'd0, 1'b0, 8'd0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
        step(1'b1, m, a, d, 1'b0, 8'd0);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b0, 4'h0, 8'd0, 32'd0, 1'b1, a);
    endtask

    // Assert reset (in-flight reads are flushed), hold, release before an edge
    task automatic apply_reset(input int hold_cycles);
        rst_n = 1'b0;
        ena = 1'b0; enb = 1'b0;
        q0.delete(); q1.delete();
        sweep_left = c_SIZE;
        for (int i = 0; i < c_SIZE; i++) model[i] = '0;
        repeat (hold_cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_sweep();
        while (sweep_left > 0) idle(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        last_out[0] = '0;
        last_out[1] = '0;
        apply_reset(3);

        // Accesses during the sweep must be ignored
        for (int k = 0; k < 5; k++) step(1'b1, 4'hF, 8'd10, 32'hFFFF_FFFF, 1'b1, 8'd10);
        wait_sweep();

        // Zero-filled contents
        rd(8'd0); rd(8'd128); rd(8'd255); rd(8'd10);
        idle(3);

        // Byte masking
        wr(8'd5, 4'b1111, 32'hDEAD_BEEF);
        wr(8'd5, 4'b0101, 32'h1122_3344);
        rd(8'd5);
        idle(2);

        // Collision bypass, and a non-colliding read in the same situation
        wr(8'd7, 4'hF, 32'hAAAA_AAAA);
        wr(8'd8, 4'hF, 32'hCCCC_CCCC);
        step(1'b1, 4'b0011, 8'd7, 32'h1234_5678, 1'b1, 8'd7);
        rd(8'd7);
        step(1'b1, 4'b1100, 8'd7, 32'h9988_7766, 1'b1, 8'd8);
        step(1'b1, 4'b0000, 8'd7, 32'h0F0F_0F0F, 1'b1, 8'd7);
        rd(8'd7);
        idle(2);

        // Back-to-back writes to one address, then read straight after
        wr(8'd20, 4'hF, 32'h0102_0304);
        wr(8'd20, 4'b1001, 32'hA0B0_C0D0);
        rd(8'd20);
        idle(2);

        // Pipelined reads on consecutive cycles, then hold
        wr(8'd1, 4'hF, 32'd1);
        wr(8'd2, 4'hF, 32'd2);
        wr(8'd3, 4'hF, 32'd3);
        rd(8'd1); rd(8'd2); rd(8'd3);
        idle(6);

        // Random traffic on a small window so collisions are frequent
        for (int k = 0; k < 200; k++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 8'(32 + $urandom_range(0, 3)),
                 $urandom, 1'($urandom_range(0, 1)), 8'(32 + $urandom_range(0, 3)));
        end
        idle(3);

        // Reset while a read is in flight: no pulse may follow
        rd(8'd5);
        apply_reset(3);

        // Reset mid-sweep restarts it from address 0
        idle(100);
        apply_reset(3);
        wait_sweep();
        rd(8'd5); rd(8'd7); rd(8'd255);
        idle(4);

        chk_eq("drain_d0", q0.size(), 32'd0);
        chk_eq("drain_d1", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
